adxl362_spi: RTL and testbench



---
 rtl/adxl362_spi_pkg.sv | 22 ++
 rtl/adxl362_sync.sv | 26 ++
 rtl/adxl362_spi.sv | 150 +++++++++++++++
 tb/tb_adxl362_spi.sv | 190 +++++++++++++++++++
 4 files changed

// File: rtl/adxl362_spi_pkg.sv
// Shared ADXL362 SPI constants: command opcodes, FSM state encoding and a
// small shift helper used by the receive path.
package adxl362_spi_pkg;

  localparam logic [7:0] ADXL362_SPI_CMD_WRITE = 8'h0A;
  localparam logic [7:0] ADXL362_SPI_CMD_READ  = 8'h0B;
  localparam logic [7:0] ADXL362_SPI_CMD_FIFO  = 8'h0D;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_CMD     = 3'd1,
    ST_ADDR    = 3'd2,
    ST_WR_DATA = 3'd3,
    ST_RD_DATA = 3'd4,
    ST_IGNORE  = 3'd5
  } spi_state_e;

  function automatic logic [7:0] shift_in(input logic [7:0] cur, input logic bit_in);
    return {cur[6:0], bit_in};
  endfunction

endpackage

// File: rtl/adxl362_sync.sv
// Two-flop synchroniser whose flops power up to a caller-chosen idle level.
module adxl362_sync (
  input  logic clk_i,
  input  logic rst_n_i,
  input  logic rst_val_i,
  input  logic d_i,
  output logic q_o
);

  logic meta_q;
  logic sync_q;

  // Double-register the asynchronous input into the clk_i domain.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      meta_q <= rst_val_i;
      sync_q <= rst_val_i;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/adxl362_spi.sv
// Oversampled SPI mode-0 slave decoding the ADXL362 register read/write
// protocol and driving the register block's write/address/data_write port.
module adxl362_spi
  import adxl362_spi_pkg::*;
(
  input  logic       clk_16mhz,
  input  logic       rst_n,
  input  logic       sclk,
  input  logic       cs_n,
  input  logic       mosi,
  output logic       miso,
  output logic       write,
  output logic [5:0] address,
  output logic [7:0] data_write,
  input  logic [7:0] data_read
);

  logic sclk_s, cs_n_s, mosi_s;

  adxl362_sync u_sync_sclk (.clk_i(clk_16mhz), .rst_n_i(rst_n), .rst_val_i(1'b0), .d_i(sclk), .q_o(sclk_s));
  adxl362_sync u_sync_cs_n (.clk_i(clk_16mhz), .rst_n_i(rst_n), .rst_val_i(1'b1), .d_i(cs_n), .q_o(cs_n_s));
  adxl362_sync u_sync_mosi (.clk_i(clk_16mhz), .rst_n_i(rst_n), .rst_val_i(1'b0), .d_i(mosi), .q_o(mosi_s));

  spi_state_e state_q;
  logic       sclk_prev_q;
  logic [2:0] bit_cnt_q;
  logic [7:0] rx_q, tx_q, data_write_q;
  logic [5:0] address_q;
  logic       wr_flag_q, wr_pend_q, write_q, rd_inc_q, rd_load_q, miso_q;

  logic       rise_s, fall_s, byte_done_s;
  logic [7:0] byte_s;

  assign rise_s      = ~sclk_prev_q & sclk_s;
  assign fall_s      = sclk_prev_q & ~sclk_s;
  assign byte_s      = shift_in(rx_q, mosi_s);
  assign byte_done_s = rise_s && (bit_cnt_q == 3'd7);

  // Protocol FSM with its strobe pipeline and the transmit shifter.
  always_ff @(posedge clk_16mhz or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      sclk_prev_q  <= 1'b0;
      bit_cnt_q    <= 3'd0;
      rx_q         <= 8'h00;
      tx_q         <= 8'h00;
      data_write_q <= 8'h00;
      address_q    <= 6'd0;
      wr_flag_q    <= 1'b0;
      wr_pend_q    <= 1'b0;
      write_q      <= 1'b0;
      rd_inc_q     <= 1'b0;
      rd_load_q    <= 1'b0;
      miso_q       <= 1'b0;
    end else begin
      sclk_prev_q <= sclk_s;
      // The write/increment pipeline runs independently of chip select so an
      // in-flight strobe always completes.
      write_q   <= wr_pend_q;
      wr_pend_q <= 1'b0;
      rd_inc_q  <= 1'b0;
      rd_load_q <= 1'b0;
      if (write_q) begin
        address_q <= address_q + 6'd1;
      end else if (rd_inc_q) begin
        address_q <= address_q + 6'd1;
        rd_load_q <= 1'b1;
      end else begin
        address_q <= address_q;
      end

      if (cs_n_s) begin
        state_q   <= ST_IDLE;
        bit_cnt_q <= 3'd0;
        rx_q      <= 8'h00;
        miso_q    <= 1'b0;
      end else begin
        if (rise_s) begin
          rx_q      <= byte_s;
          bit_cnt_q <= bit_cnt_q + 3'd1;
        end else begin
          rx_q      <= rx_q;
        end

        case (state_q)
          ST_IDLE: begin
            state_q   <= ST_CMD;
            bit_cnt_q <= 3'd0;
            rx_q      <= 8'h00;
          end
          ST_CMD: begin
            if (byte_done_s) begin
              case (byte_s)
                ADXL362_SPI_CMD_WRITE: begin state_q <= ST_ADDR; wr_flag_q <= 1'b1; end
                ADXL362_SPI_CMD_READ:  begin state_q <= ST_ADDR; wr_flag_q <= 1'b0; end
                ADXL362_SPI_CMD_FIFO:  state_q <= ST_IGNORE;
                default:               state_q <= ST_IGNORE;
              endcase
            end
          end
          ST_ADDR: begin
            if (byte_done_s) begin
              address_q <= byte_s[5:0];
              if (wr_flag_q) begin
                state_q <= ST_WR_DATA;
              end else begin
                state_q   <= ST_RD_DATA;
                rd_load_q <= 1'b1;
              end
            end
          end
          ST_WR_DATA: begin
            if (byte_done_s) begin
              data_write_q <= byte_s;
              wr_pend_q    <= 1'b1;
            end
          end
          ST_RD_DATA: begin
            if (byte_done_s) begin
              rd_inc_q <= 1'b1;
            end
          end
          ST_IGNORE: state_q <= ST_IGNORE;
          default:   state_q <= ST_IDLE;
        endcase

        // miso tracks tx bit 7 while reading; the fall after a byte boundary never shifts.
        if (state_q == ST_RD_DATA) begin
          if (rd_load_q) begin
            tx_q   <= data_read;
            miso_q <= data_read[7];
          end else if (fall_s && (bit_cnt_q != 3'd0)) begin
            tx_q   <= {tx_q[6:0], 1'b0};
            miso_q <= tx_q[6];
          end else begin
            miso_q <= tx_q[7];
          end
        end else begin
          miso_q <= 1'b0;
        end
      end
    end
  end

  assign miso       = miso_q;
  assign write      = write_q;
  assign address    = address_q;
  assign data_write = data_write_q;

endmodule

// File: tb/tb_adxl362_spi.sv
// Directed bench for adxl362_spi with a small ADXL362 register-file model
// (0x00..0x03 read-only ID registers, the rest writable on posedge write).
module tb_adxl362_spi;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       sclk = 1'b0;
  logic       cs_n = 1'b1;
  logic       mosi = 1'b0;
  logic       miso;
  logic       write;
  logic [5:0] address;
  logic [7:0] data_write;
  logic [7:0] data_read;

  int total = 0;
  int bad = 0;

  adxl362_spi dut (
    .clk_16mhz (clk),
    .rst_n     (rst_n),
    .sclk      (sclk),
    .cs_n      (cs_n),
    .mosi      (mosi),
    .miso      (miso),
    .write     (write),
    .address   (address),
    .data_write(data_write),
    .data_read (data_read)
  );

  always #5 clk = ~clk;

  bit [7:0] mem [64];

  always @(posedge write) begin
    if (address > 6'd3) mem[address] <= data_write;
  end

  assign data_read = (address == 6'd0) ? 8'hAD :
                     (address == 6'd1) ? 8'h1D :
                     (address == 6'd2) ? 8'hF2 :
                     (address == 6'd3) ? 8'h02 : mem[address];

  int       wr_cnt = 0;
  int       miso_hi_cnt = 0;
  int       long_pulse = 0;
  logic     write_prev = 1'b0;
  logic [5:0] wr_addr [64];
  logic [7:0] wr_data [64];

  always @(negedge clk) begin
    if (write) begin
      wr_addr[wr_cnt[5:0]] = address;
      wr_data[wr_cnt[5:0]] = data_write;
      wr_cnt = wr_cnt + 1;
      if (write_prev) long_pulse = long_pulse + 1;
    end
    if (miso) miso_hi_cnt = miso_hi_cnt + 1;
    write_prev = write;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic spi_bits(input logic [7:0] d, input int n, output logic [7:0] r);
    r = 8'h00;
    for (int i = 0; i < n; i++) begin
      mosi = d[7 - i];
      repeat (8) @(negedge clk);
      r = {r[6:0], miso};
      sclk = 1'b1;
      repeat (8) @(negedge clk);
      sclk = 1'b0;
    end
  endtask

  task automatic spi_byte(input logic [7:0] d, output logic [7:0] r);
    spi_bits(d, 8, r);
  endtask

  task automatic cs_start();
    cs_n = 1'b0;
    repeat (8) @(negedge clk);
  endtask

  task automatic cs_end();
    repeat (8) @(negedge clk);
    cs_n = 1'b1;
    repeat (12) @(negedge clk);
  endtask

  initial begin
    logic [7:0] r;
    int         wbase;
    int         mbase;
    logic [5:0] abase;

    #1;
    check("rst_write", {31'd0, write}, 32'd0);
    check("rst_address", {26'd0, address}, 32'd0);
    check("rst_data_write", {24'd0, data_write}, 32'd0);
    check("rst_miso", {31'd0, miso}, 32'd0);
    repeat (4) @(negedge clk);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);

    // single write
    wbase = wr_cnt; mbase = miso_hi_cnt;
    cs_start(); spi_byte(8'h0A, r); spi_byte(8'h20, r); spi_byte(8'hFA, r); cs_end();
    check("sw_pulses", wr_cnt - wbase, 32'd1);
    check("sw_addr", {26'd0, wr_addr[wbase[5:0]]}, 32'h20);
    check("sw_data", {24'd0, wr_data[wbase[5:0]]}, 32'hFA);
    check("sw_miso_quiet", miso_hi_cnt - mbase, 32'd0);
    check("sw_addr_after", {26'd0, address}, 32'h21);
    check("sw_mem", {24'd0, mem[32]}, 32'hFA);

    // burst write with address wrap
    wbase = wr_cnt;
    cs_start(); spi_byte(8'h0A, r); spi_byte(8'h3E, r);
    spi_byte(8'h11, r); spi_byte(8'h22, r); spi_byte(8'h33, r); cs_end();
    check("bw_pulses", wr_cnt - wbase, 32'd3);
    check("bw_addr0", {26'd0, wr_addr[wbase[5:0]]}, 32'h3E);
    check("bw_data0", {24'd0, wr_data[wbase[5:0]]}, 32'h11);
    check("bw_addr1", {26'd0, wr_addr[6'(wbase + 1)]}, 32'h3F);
    check("bw_data1", {24'd0, wr_data[6'(wbase + 1)]}, 32'h22);
    check("bw_addr2", {26'd0, wr_addr[6'(wbase + 2)]}, 32'h00);
    check("bw_data2", {24'd0, wr_data[6'(wbase + 2)]}, 32'h33);
    check("bw_addr_after", {26'd0, address}, 32'h01);
    check("bw_mem3f", {24'd0, mem[63]}, 32'h22);

    // burst read
    wbase = wr_cnt;
    cs_start(); spi_byte(8'h0B, r); spi_byte(8'h00, r);
    spi_byte(8'h00, r); check("br_byte0", {24'd0, r}, 32'hAD);
    spi_byte(8'hFF, r); check("br_byte1", {24'd0, r}, 32'h1D);
    spi_byte(8'h00, r); check("br_byte2", {24'd0, r}, 32'hF2);
    cs_end();
    check("br_addr_after", {26'd0, address}, 32'h03);
    check("br_no_write", wr_cnt - wbase, 32'd0);

    // unknown command
    wbase = wr_cnt; mbase = miso_hi_cnt; abase = address;
    cs_start(); spi_byte(8'h55, r); spi_byte(8'h0A, r); spi_byte(8'hFF, r); cs_end();
    check("unk_no_write", wr_cnt - wbase, 32'd0);
    check("unk_miso_quiet", miso_hi_cnt - mbase, 32'd0);
    check("unk_addr", {26'd0, address}, {26'd0, abase});

    // CS abort mid data byte, then a clean write
    wbase = wr_cnt;
    cs_start(); spi_byte(8'h0A, r); spi_byte(8'h2C, r); spi_bits(8'hA5, 4, r); cs_end();
    check("abort_no_write", wr_cnt - wbase, 32'd0);
    check("abort_addr", {26'd0, address}, 32'h2C);
    wbase = wr_cnt;
    cs_start(); spi_byte(8'h0A, r); spi_byte(8'h2D, r); spi_byte(8'h02, r); cs_end();
    check("abort_next_pulses", wr_cnt - wbase, 32'd1);
    check("abort_next_addr", {26'd0, wr_addr[wbase[5:0]]}, 32'h2D);
    check("abort_next_mem", {24'd0, mem[45]}, 32'h02);
    check("abort_mem2c", {24'd0, mem[44]}, 32'h00);
    check("single_cycle_write", long_pulse, 32'd0);

    // reset during a burst read
    cs_start(); spi_byte(8'h0B, r); spi_byte(8'h01, r);
    spi_byte(8'h00, r); check("rr_byte0", {24'd0, r}, 32'h1D);
    spi_bits(8'h00, 3, r);
    rst_n = 1'b0;
    #1;
    check("rr_address", {26'd0, address}, 32'd0);
    check("rr_write", {31'd0, write}, 32'd0);
    check("rr_data_write", {24'd0, data_write}, 32'd0);
    check("rr_miso", {31'd0, miso}, 32'd0);
    cs_n = 1'b1;
    repeat (8) @(negedge clk);
    rst_n = 1'b1;
    repeat (8) @(negedge clk);
    cs_start(); spi_byte(8'h0B, r); spi_byte(8'h02, r);
    spi_byte(8'h00, r); check("rr_after_byte", {24'd0, r}, 32'hF2);
    cs_end();
    check("rr_after_addr", {26'd0, address}, 32'h03);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
